// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Holds the FSM state encoding and the default operand width, iteration count and counter width.
// Optional build macro used by importers: MULDIV_SEQ_MULT_EN (iterative multiply on the divider adder).
package muldiv_pkg;
   localparam int DEF_WIDTH     = 32;
   localparam int DEF_DIV_ITERS = DEF_WIDTH;
   localparam int DEF_CNT_W     = $clog2(DEF_DIV_ITERS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;
endpackage

// File: rtl/div_core.sv
// Iterative restoring divider datapath: one quotient bit per step through a shared adder.
// Latency: one step per cycle; step results (hi_n/lo_n) are combinational from the current registers.
// No backpressure: the controller pulses load once, then asserts step per cycle; clear wipes state.
// Ports: load/step/clear/mul controls, a/b magnitudes in, hi_n/lo_n = remainder/quotient after this step.
// With mul high the same adder performs a shift-add multiply step (hi_n:lo_n = partial product).
module div_core
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             load,
   input  logic             step,
   input  logic             clear,
   input  logic             mul,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi_n,
   output logic [WIDTH-1:0] lo_n
);
   logic [WIDTH-1:0] acc;   // partial remainder / high product half
   logic [WIDTH-1:0] quo;   // dividend shifting out, quotient shifting in / low product half
   logic [WIDTH-1:0] dvs;   // divisor / multiplicand
   logic [WIDTH:0]   x, y;
   logic [WIDTH+1:0] sum;

   // Divide: trial subtract of the shifted remainder; carry out means no borrow.
   // Multiply: plain add of the multiplicand into the high half.
   assign x   = mul ? {1'b0, acc} : {acc, quo[WIDTH-1]};
   assign y   = mul ? {1'b0, dvs} : ~{1'b0, dvs};
   assign sum = {1'b0, x} + {1'b0, y} + {{(WIDTH+1){1'b0}}, !mul};

   always_comb begin
      hi_n = acc;
      lo_n = quo;
      if (mul) begin
         if (quo[0]) begin
            hi_n = sum[WIDTH:1];
            lo_n = {sum[0], quo[WIDTH-1:1]};
         end else begin
            hi_n = {1'b0, acc[WIDTH-1:1]};
            lo_n = {acc[0], quo[WIDTH-1:1]};
         end
      end else begin
         if (sum[WIDTH+1]) begin
            hi_n = sum[WIDTH-1:0];
            lo_n = {quo[WIDTH-2:0], 1'b1};
         end else begin
            hi_n = {acc[WIDTH-2:0], quo[WIDTH-1]};
            lo_n = {quo[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         acc <= '0;
         quo <= '0;
         dvs <= '0;
      end else if (clear) begin
         acc <= '0;
         quo <= '0;
         dvs <= '0;
      end else if (load) begin
         acc <= '0;
         quo <= a;
         dvs <= b;
      end else if (step) begin
         acc <= hi_n;
         quo <= lo_n;
      end
   end
endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: accepts one MULT/MULTU/DIV/DIVU, runs it, pulses hilo_we once.
// Latency from accept: mult 2 (33 with MULDIV_SEQ_MULT_EN), div 33, divide-by-zero 1.
// Holds the pipeline with combinational stall_o while busy; flush cancels work and suppresses the write.
// Ports: start/ismult/signedmult/isdiv/signeddiv/opa/opb/flush in; stall_o, hi_o, lo_o, hilo_we out.
// Build macro MULDIV_SEQ_MULT_EN: multiply runs as a shift-add through div_core instead of '*'.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DIV_ITERS = WIDTH
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             ismult,
   input  logic             signedmult,
   input  logic             isdiv,
   input  logic             signeddiv,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic             flush,
   output logic             stall_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             hilo_we
);
   localparam int               CNT_W = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV_ITERS - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] count;
   logic             accept, div0, op_sgn, sa, sb;
   logic             neg_q, neg_r;
   logic             core_step, core_mul;
   logic [WIDTH-1:0] mag_a, mag_b, core_hi, core_lo;

   assign div0   = (opb == '0);
   assign accept = (state == IDLE) && start && (ismult || isdiv) && !flush;
   assign op_sgn = ismult ? signedmult : signeddiv;
   assign sa     = op_sgn & opa[WIDTH-1];
   assign sb     = op_sgn & opb[WIDTH-1];
   // Most-negative operand negates to itself, which is the right unsigned magnitude.
   assign mag_a  = sa ? -opa : opa;
   assign mag_b  = sb ? -opb : opb;

   assign stall_o = resetn && (accept || (state == MUL) || (state == DIV));
   assign hilo_we = (state == DONE) && !flush;

`ifdef MULDIV_SEQ_MULT_EN
   assign core_mul  = (state == MUL);
   assign core_step = !flush && ((state == MUL) || (state == DIV));
`else
   logic [2*WIDTH-1:0] ext_a, ext_b, prod;
   assign core_mul  = 1'b0;
   assign core_step = !flush && (state == DIV);
   // Sign/zero-extended operands: the low 2*WIDTH bits of the product are exact either way.
   assign prod      = ext_a * ext_b;
`endif

   div_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .resetn (resetn),
      .load   (accept),
      .step   (core_step),
      .clear  (flush),
      .mul    (core_mul),
      .a      (mag_a),
      .b      (mag_b),
      .hi_n   (core_hi),
      .lo_n   (core_lo)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = ismult ? MUL : (div0 ? DONE : DIV);
`ifdef MULDIV_SEQ_MULT_EN
         MUL:  if (count == LAST) state_nxt = DONE;
`else
         MUL:  state_nxt = DONE;
`endif
         DIV:  if (count == LAST) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_nxt;
         if (!flush && ((state == MUL) || (state == DIV))) count <= count + CNT_W'(1);
         else count <= '0;
      end
   end

   // Operand-side capture at accept; later input changes are ignored.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         neg_q <= 1'b0;
         neg_r <= 1'b0;
`ifndef MULDIV_SEQ_MULT_EN
         ext_a <= '0;
         ext_b <= '0;
`endif
      end else if (accept) begin
         neg_q <= sa ^ sb;
         neg_r <= sa;
`ifndef MULDIV_SEQ_MULT_EN
         ext_a <= {{WIDTH{sa}}, opa};
         ext_b <= {{WIDTH{sb}}, opb};
`endif
      end
   end

   // Results land on the edge into DONE so they are valid alongside hilo_we.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hi_o <= '0;
         lo_o <= '0;
      end else if (!flush) begin
         if (accept && !ismult && div0) begin
            hi_o <= opa;
            lo_o <= '1;
         end else if ((state == DIV) && (count == LAST)) begin
            lo_o <= neg_q ? -core_lo : core_lo;
            hi_o <= neg_r ? -core_hi : core_hi;
`ifdef MULDIV_SEQ_MULT_EN
         end else if ((state == MUL) && (count == LAST)) begin
            {hi_o, lo_o} <= neg_q ? -{core_hi, core_lo} : {core_hi, core_lo};
`else
         end else if (state == MUL) begin
            {hi_o, lo_o} <= prod;
`endif
         end
      end
   end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, multi-cycle corner sequences
// (flush, flush in DONE, reset mid-op) and random ops against an arithmetic reference model.
module tb_muldiv_ctrl;
`ifdef MULDIV_SEQ_MULT_EN
   localparam int MLAT = 33;
`else
   localparam int MLAT = 2;
`endif
   localparam int DLAT = 33;

   logic        clk = 1'b0;
   logic        resetn, start, ismult, signedmult, isdiv, signeddiv, flush;
   logic [31:0] opa, opb;
   logic        stall_o, hilo_we;
   logic [31:0] hi_o, lo_o;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   muldiv_ctrl dut (
      .clk(clk), .resetn(resetn), .start(start), .ismult(ismult), .signedmult(signedmult),
      .isdiv(isdiv), .signeddiv(signeddiv), .opa(opa), .opb(opb), .flush(flush),
      .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o), .hilo_we(hilo_we)
   );

   typedef struct {
      string       name;
      bit          ism;
      bit          sgn;
      logic [31:0] a, b, ehi, elo;
      int          lat;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic on the architectural rules.
   task automatic model(input bit ism, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output int lat);
      longint          sa, sb, sq, sr;
      longint unsigned ua, ub, up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      if (ism) begin
         lat = MLAT;
         up  = sgn ? longint'(sa * sb) : ua * ub;
         hi  = up[63:32];
         lo  = up[31:0];
      end else if (b == 0) begin
         lat = 1;
         hi  = a;
         lo  = 32'hFFFF_FFFF;
      end else begin
         lat = DLAT;
         if (sgn) begin
            sq = sa / sb;
            sr = sa % sb;
            hi = sr[31:0];
            lo = sq[31:0];
         end else begin
            up = ua / ub;
            hi = 32'(ua % ub);
            lo = up[31:0];
         end
      end
   endtask

   // Called at a negedge: present the op and check the accept-cycle stall.
   task automatic issue_now(input bit ism, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                            input string nm);
      ismult = ism; isdiv = !ism; signedmult = sgn; signeddiv = sgn;
      opa = a; opb = b; start = 1'b1;
      #1;
      chk({nm, " stall@0"}, {63'b0, stall_o}, 64'd1);
      chk({nm, " we@0"}, {63'b0, hilo_we}, 64'd0);
   endtask

   // Walk cycles 1..lat+1 after accept, scrambling inputs to prove they were captured.
   task automatic follow(input int lat, input logic [31:0] ehi, input logic [31:0] elo, input string nm);
      for (int c = 1; c <= lat + 1; c++) begin
         @(negedge clk);
         start = 1'b0; opa = $urandom; opb = $urandom;
         signedmult = 1'($urandom); signeddiv = 1'($urandom);
         #1;
         chk($sformatf("%s stall@%0d", nm, c), {63'b0, stall_o}, {63'b0, (c < lat)});
         chk($sformatf("%s we@%0d", nm, c), {63'b0, hilo_we}, {63'b0, (c == lat)});
         if (c == lat) begin
            chk({nm, " hi"}, {32'b0, hi_o}, {32'b0, ehi});
            chk({nm, " lo"}, {32'b0, lo_o}, {32'b0, elo});
         end
      end
   endtask

   task automatic run_model_op(input bit ism, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                               input string nm);
      logic [31:0] ehi, elo;
      int          lat;
      model(ism, sgn, a, b, ehi, elo, lat);
      @(negedge clk);
      issue_now(ism, sgn, a, b, nm);
      follow(lat, ehi, elo, nm);
   endtask

   vec_t        vt[$];
   logic [31:0] rhi, rlo, ra, rb;

   initial begin
      resetn = 1'b0; start = 1'b1; ismult = 1'b1; isdiv = 1'b0;
      signedmult = 1'b0; signeddiv = 1'b0; flush = 1'b0; opa = 32'd3; opb = 32'd4;

      vt.push_back('{"divu_100_7",   0, 0, 32'd100,       32'd7,         32'd2,         32'd14,        DLAT});
      vt.push_back('{"div_m7_2",     0, 1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DLAT});
      vt.push_back('{"div_ovf",      0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, DLAT});
      vt.push_back('{"div_7_m2",     0, 1, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, DLAT});
      vt.push_back('{"divu_max_1",   0, 0, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, DLAT});
      vt.push_back('{"divu_3_7",     0, 0, 32'd3,         32'd7,         32'd3,         32'd0,         DLAT});
      vt.push_back('{"mult_m1_2",    1, 1, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, MLAT});
      vt.push_back('{"multu_m1_2",   1, 0, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'hFFFF_FFFE, MLAT});
      vt.push_back('{"mult_min_min", 1, 1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         MLAT});
      vt.push_back('{"divu_5_0",     0, 0, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1});
      vt.push_back('{"div_m5_0",     0, 1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1});
      vt.push_back('{"multu_big",    1, 0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 32'h242D_2080, MLAT});

      // Reset state, with a would-be accept on the inputs.
      #7;
      chk("rst stall", {63'b0, stall_o}, 64'd0);
      chk("rst we", {63'b0, hilo_we}, 64'd0);
      chk("rst hi", {32'b0, hi_o}, 64'd0);
      chk("rst lo", {32'b0, lo_o}, 64'd0);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      resetn = 1'b1;

      foreach (vt[i]) begin
         @(negedge clk);
         issue_now(vt[i].ism, vt[i].sgn, vt[i].a, vt[i].b, vt[i].name);
         follow(vt[i].lat, vt[i].ehi, vt[i].elo, vt[i].name);
      end

      // Flush at cycle 10 of a DIV; restart in cycle 11. Previous result was multu_big.
      @(negedge clk);
      issue_now(1'b0, 1'b0, 32'd100, 32'd7, "flushdiv");
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 10) flush = 1'b1;
         #1;
         chk($sformatf("flushdiv stall@%0d", c), {63'b0, stall_o}, 64'd1);
         chk($sformatf("flushdiv we@%0d", c), {63'b0, hilo_we}, 64'd0);
      end
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flushdiv stall@11", {63'b0, stall_o}, 64'd0);
      chk("flushdiv we@11", {63'b0, hilo_we}, 64'd0);
      chk("flushdiv hi kept", {32'b0, hi_o}, 64'h0B00_EA4E);
      chk("flushdiv lo kept", {32'b0, lo_o}, 64'h242D_2080);
      issue_now(1'b0, 1'b0, 32'd9, 32'd3, "divu_9_3");
      follow(DLAT, 32'd0, 32'd3, "divu_9_3");

      // Flush during DONE suppresses the write.
      @(negedge clk);
      issue_now(1'b0, 1'b0, 32'd5, 32'd0, "flushdone");
      @(negedge clk);
      start = 1'b0; flush = 1'b1;
      #1;
      chk("flushdone we", {63'b0, hilo_we}, 64'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flushdone we+1", {63'b0, hilo_we}, 64'd0);
      chk("flushdone stall+1", {63'b0, stall_o}, 64'd0);

      // Flush coincident with start wins: nothing accepted.
      @(negedge clk);
      ismult = 1'b1; isdiv = 1'b0; opa = 32'd6; opb = 32'd7; start = 1'b1; flush = 1'b1;
      #1;
      chk("flushstart stall", {63'b0, stall_o}, 64'd0);
      for (int c = 1; c <= MLAT + 1; c++) begin
         @(negedge clk);
         start = 1'b0; flush = 1'b0;
         #1;
         chk($sformatf("flushstart we@%0d", c), {63'b0, hilo_we}, 64'd0);
      end

      // Async reset in cycle 20 of a DIV; preload nonzero HI/LO first.
      run_model_op(1'b0, 1'b0, 32'd100, 32'd7, "pre_rst");
      @(negedge clk);
      issue_now(1'b0, 1'b1, 32'hFFFF_FF00, 32'd3, "rstdiv");
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      resetn = 1'b0;
      #1;
      chk("rstdiv hi", {32'b0, hi_o}, 64'd0);
      chk("rstdiv lo", {32'b0, lo_o}, 64'd0);
      chk("rstdiv we", {63'b0, hilo_we}, 64'd0);
      chk("rstdiv stall", {63'b0, stall_o}, 64'd0);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         #1;
         if (c == 39) chk("rstdiv no write", {63'b0, hilo_we}, 64'd0);
      end
      resetn = 1'b1;
      run_model_op(1'b0, 1'b1, 32'hFFFF_FF00, 32'd3, "post_rst");

      // Random ops with a sprinkling of edge operands.
      for (int i = 0; i < 60; i++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            2: ra = 32'h8000_0000;
            3: rb = 32'($urandom_range(1, 15));
            default: ;
         endcase
         run_model_op(1'($urandom), 1'($urandom), ra, rb, $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
